// File: rtl/mem_access_unit.sv
// Single-request load/store front end for a big-endian byte-addressed RAM with async read.
// Define MEM_ACCESS_MISALIGN_CHECK_EN to reject misaligned half/word requests.
module mem_access_unit #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 12
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_req_valid,
   output logic                    o_req_ready,
   input  logic                    i_req_write,
   input  logic [1:0]              i_req_size,
   input  logic                    i_req_unsigned,
   input  logic [ADDR_WIDTH-1:0]   i_req_addr,
   input  logic [DATA_WIDTH*4-1:0] i_req_wdata,
   output logic                    o_resp_valid,
   input  logic                    i_resp_ready,
   output logic [DATA_WIDTH*4-1:0] o_resp_rdata,
   output logic                    o_resp_error,
   output logic                    o_mem_we,
   output logic [1:0]              o_mem_width,
   output logic [ADDR_WIDTH-1:0]   o_mem_addr,
   output logic [DATA_WIDTH*4-1:0] o_mem_wdata,
   input  logic [DATA_WIDTH*4-1:0] i_mem_rdata
);

   localparam int unsigned BUS_W  = DATA_WIDTH * 4;
   localparam int unsigned HALF_W = DATA_WIDTH * 2;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_e;

   state_e                  state_q, state_d;
   logic                    write_q, write_d;
   logic [1:0]              size_q, size_d;
   logic                    uns_q, uns_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [BUS_W-1:0]        wdata_q, wdata_d;
   logic [BUS_W-1:0]        rdata_q, rdata_d;
   logic                    error_q, error_d;

   logic                    req_err;
   logic                    sign_bit;
   logic [BUS_W-1:0]        load_data;

   always_comb begin
      req_err = (size_q == 2'b10);
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
      if ((size_q == 2'b01) && addr_q[0]) begin
         req_err = 1'b1;
      end
      if ((size_q == 2'b11) && (addr_q[1:0] != 2'b00)) begin
         req_err = 1'b1;
      end
`endif
   end

   // Byte at the request address sits in the top lane of the read bus.
   always_comb begin
      load_data = i_mem_rdata;
      sign_bit  = ~uns_q & i_mem_rdata[BUS_W-1];
      case (size_q)
         2'b00:   load_data = {{(BUS_W-DATA_WIDTH){sign_bit}}, i_mem_rdata[BUS_W-1 -: DATA_WIDTH]};
         2'b01:   load_data = {{(BUS_W-HALF_W){sign_bit}}, i_mem_rdata[BUS_W-1 -: HALF_W]};
         default: load_data = i_mem_rdata;
      endcase
   end

   always_comb begin
      state_d = state_q;
      write_d = write_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      error_d = error_q;
      case (state_q)
         IDLE: begin
            if (i_req_valid) begin
               write_d = i_req_write;
               size_d  = i_req_size;
               uns_d   = i_req_unsigned;
               addr_d  = i_req_addr;
               wdata_d = i_req_wdata;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            rdata_d = (!write_q && !req_err) ? load_data : '0;
            error_d = req_err;
            state_d = RESP;
         end
         RESP: begin
            if (i_resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= IDLE;
         write_q <= 1'b0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         error_q <= error_d;
      end
   end

   // Decoded from the state flop so reset kills a write without waiting for a clock.
   assign o_mem_we     = (state_q == ACCESS) & write_q & ~req_err;
   assign o_req_ready  = (state_q == IDLE);
   assign o_resp_valid = (state_q == RESP);
   assign o_resp_rdata = rdata_q;
   assign o_resp_error = error_q;
   assign o_mem_width  = size_q;
   assign o_mem_addr   = addr_q;
   assign o_mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, handshake/reset
// sequences and randomized requests against a byte-array reference model.
module tb_mem_access_unit;

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_write, req_uns;
   logic [1:0]  req_size;
   logic [11:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid, resp_ready, resp_error;
   logic [31:0] resp_rdata;
   logic        mem_we;
   logic [1:0]  mem_width;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(12)) dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_req_valid    (req_valid),
      .o_req_ready    (req_ready),
      .i_req_write    (req_write),
      .i_req_size     (req_size),
      .i_req_unsigned (req_uns),
      .i_req_addr     (req_addr),
      .i_req_wdata    (req_wdata),
      .o_resp_valid   (resp_valid),
      .i_resp_ready   (resp_ready),
      .o_resp_rdata   (resp_rdata),
      .o_resp_error   (resp_error),
      .o_mem_we       (mem_we),
      .o_mem_width    (mem_width),
      .o_mem_addr     (mem_addr),
      .o_mem_wdata    (mem_wdata),
      .i_mem_rdata    (mem_rdata)
   );

   // Big-endian RAM with async read and byte/half/word writes
   logic [7:0] ram [4096] = '{default: 8'h00};
   assign mem_rdata = {ram[mem_addr], ram[mem_addr + 12'd1], ram[mem_addr + 12'd2], ram[mem_addr + 12'd3]};
   always @(posedge clk) begin
      if (mem_we) begin
         case (mem_width)
            2'b00: ram[mem_addr] <= mem_wdata[7:0];
            2'b01: begin
               ram[mem_addr]         <= mem_wdata[15:8];
               ram[mem_addr + 12'd1] <= mem_wdata[7:0];
            end
            2'b11: begin
               ram[mem_addr]         <= mem_wdata[31:24];
               ram[mem_addr + 12'd1] <= mem_wdata[23:16];
               ram[mem_addr + 12'd2] <= mem_wdata[15:8];
               ram[mem_addr + 12'd3] <= mem_wdata[7:0];
            end
            default: ;
         endcase
      end
   end

   // Reference memory image, updated only from request semantics
   logic [7:0] ref_mem [4096] = '{default: 8'h00};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic model(input logic w, input logic [1:0] sz, input logic u, input logic [11:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er, output int we);
      int n;
      logic [31:0] v;
      er = (sz == 2'b10);
      if (CHK && sz == 2'b01 && a[0]) er = 1'b1;
      if (CHK && sz == 2'b11 && a[1:0] != 2'b00) er = 1'b1;
      n  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      rd = 32'h0;
      we = (w && !er) ? 1 : 0;
      if (er) return;
      if (w) begin
         for (int i = 0; i < n; i++) ref_mem[12'(a + 12'(i))] = wd[8*(n-1-i) +: 8];
      end else begin
         v = 32'h0;
         for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[12'(a + 12'(i))]);
         if (!u && n < 4 && v[8*n-1]) v = v - (32'd1 << (8*n));
         rd = v;
      end
   endtask

   task automatic run_req(input logic w, input logic [1:0] sz, input logic u, input logic [11:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int we_cnt, output int lat);
      bit got;
      @(negedge clk);
      check("idle_ready", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_write  = w;
      req_size   = sz;
      req_uns    = u;
      req_addr   = a;
      req_wdata  = wd;
      resp_ready = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      we_cnt = 0;
      lat    = 0;
      got    = 1'b0;
      rd     = 32'h0;
      er     = 1'b0;
      for (int cyc = 1; cyc <= 20 && !got; cyc++) begin
         @(negedge clk);
         if (mem_we) begin
            we_cnt++;
            check("we_addr", 32'(mem_addr), 32'(a));
            check("we_width", 32'(mem_width), 32'(sz));
            check("we_wdata", mem_wdata, wd);
         end
         if (resp_valid) begin
            got = 1'b1;
            lat = cyc;
            rd  = resp_rdata;
            er  = resp_error;
         end
      end
      if (!got) check("resp_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        w;
      logic [1:0]  sz;
      logic        u;
      logic [11:0] a;
      logic [31:0] wd;
      logic [31:0] erd;
      logic        eer;
      int          ewe;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic w, input logic [1:0] sz, input logic u, input logic [11:0] a,
                      input logic [31:0] wd, input logic [31:0] erd, input logic eer, input int ewe);
      vec_t v;
      v.w = w; v.sz = sz; v.u = u; v.a = a; v.wd = wd;
      v.erd = erd; v.eer = eer; v.ewe = ewe;
      vecs.push_back(v);
   endtask

   initial begin
      logic [31:0] rd, mrd, held;
      logic        er, mer;
      int          wec, lat, mwe;
      bit          got;
      logic        w, u;
      logic [1:0]  sz;
      logic [11:0] a;
      logic [31:0] wd;

      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_uns = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
      #12;
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_rdata", resp_rdata, 32'd0);
      check("rst_error", 32'(resp_error), 32'd0);
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_width", 32'(mem_width), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // w, size, unsigned, addr, wdata, exp rdata, exp error, exp write pulses
      add(1, 2'b11, 0, 12'h010, 32'hDEADBEEF, 32'h0, 0, 1);
      add(0, 2'b11, 0, 12'h010, 32'h0, 32'hDEADBEEF, 0, 0);
      add(0, 2'b00, 0, 12'h011, 32'h0, 32'hFFFFFFAD, 0, 0);
      add(0, 2'b01, 0, 12'h012, 32'h0, 32'hFFFFBEEF, 0, 0);
      add(1, 2'b00, 0, 12'h020, 32'h12345680, 32'h0, 0, 1);
      add(1, 2'b00, 0, 12'h021, 32'h00000001, 32'h0, 0, 1);
      add(0, 2'b00, 0, 12'h020, 32'h0, 32'hFFFFFF80, 0, 0);
      add(0, 2'b00, 1, 12'h020, 32'h0, 32'h00000080, 0, 0);
      add(0, 2'b01, 0, 12'h020, 32'h0, 32'hFFFF8001, 0, 0);
      add(0, 2'b01, 1, 12'h020, 32'h0, 32'h00008001, 0, 0);
      add(1, 2'b10, 0, 12'h030, 32'hFFFFFFFF, 32'h0, 1, 0);
      add(0, 2'b10, 0, 12'h030, 32'h0, 32'h0, 1, 0);
      add(1, 2'b01, 0, 12'h041, 32'h0000BEEF, 32'h0, CHK, CHK ? 0 : 1);
      add(0, 2'b01, 1, 12'h041, 32'h0, CHK ? 32'h0 : 32'h0000BEEF, CHK, 0);
      add(0, 2'b11, 0, 12'h040, 32'h0, CHK ? 32'h0 : 32'h00BEEF00, 0, 0);
      add(1, 2'b11, 0, 12'hFFC, 32'h11223344, 32'h0, 0, 1);
      add(1, 2'b00, 0, 12'h000, 32'h00000055, 32'h0, 0, 1);
      add(0, 2'b11, 1, 12'hFFE, 32'h0, CHK ? 32'h0 : 32'h33445500, CHK, 0);
      add(0, 2'b01, 0, 12'hFFF, 32'h0, CHK ? 32'h0 : 32'h00004455, CHK, 0);

      foreach (vecs[i]) begin
         run_req(vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].wd, rd, er, wec, lat);
         model(vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].wd, mrd, mer, mwe);
         check($sformatf("vec%0d_rdata", i), rd, vecs[i].erd);
         check($sformatf("vec%0d_error", i), 32'(er), 32'(vecs[i].eer));
         check($sformatf("vec%0d_we_pulses", i), 32'(wec), 32'(vecs[i].ewe));
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      end

      // Response back-pressure with a competing request held on the input
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'b11; req_uns = 1'b0;
      req_addr = 12'h010; req_wdata = 32'h0; resp_ready = 1'b0;
      @(posedge clk);
      #1 req_addr = 12'h020; req_size = 2'b00; req_uns = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(negedge clk);
         got = resp_valid;
      end
      check("bp_resp_seen", 32'(got), 32'd1);
      held = resp_rdata;
      check("bp_rdata", held, 32'hDEADBEEF);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp_rdata_stable", resp_rdata, 32'hDEADBEEF);
         check("bp_req_ready", 32'(req_ready), 32'd0);
         check("bp_resp_valid", 32'(resp_valid), 32'd1);
         check("bp_addr_held", 32'(mem_addr), 32'h010);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_back_idle", 32'(req_ready), 32'd1);
      check("bp_resp_dropped", 32'(resp_valid), 32'd0);
      @(posedge clk);
      #1 req_valid = 1'b0;
      check("bp_new_accepted", 32'(req_ready), 32'd0);
      check("bp_new_addr", 32'(mem_addr), 32'h020);
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(negedge clk);
         got = resp_valid;
      end
      check("bp_new_resp_seen", 32'(got), 32'd1);
      check("bp_new_rdata", resp_rdata, 32'h00000080);
      @(posedge clk);
      #1;

      // Reset asserted while a store is in its access cycle
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b11; req_uns = 1'b0;
      req_addr = 12'h100; req_wdata = 32'hCAFEF00D;
      @(posedge clk);
      #1 req_valid = 1'b0;
      check("rstmid_we_before", 32'(mem_we), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rstmid_we_dropped", 32'(mem_we), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rstmid_ready", 32'(req_ready), 32'd1);
      check("rstmid_resp_valid", 32'(resp_valid), 32'd0);
      check("rstmid_no_write", 32'({ram[12'h100], ram[12'h101], ram[12'h102], ram[12'h103]}), 32'h0);

      // Randomized requests clustered around a low region and the wrap boundary
      for (int i = 0; i < 300; i++) begin
         w  = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         u  = 1'($urandom_range(0, 1));
         a  = ($urandom_range(0, 1) == 1) ? (12'hFF0 | 12'($urandom_range(0, 15)))
                                          : 12'($urandom_range(0, 15));
         wd = $urandom;
         run_req(w, sz, u, a, wd, rd, er, wec, lat);
         model(w, sz, u, a, wd, mrd, mer, mwe);
         check("rnd_rdata", rd, mrd);
         check("rnd_error", 32'(er), 32'(mer));
         check("rnd_we_pulses", 32'(wec), 32'(mwe));
         check("rnd_latency", 32'(lat), 32'd2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
